// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the cipher datapath and key expansion.
// Contents:
//   state_t      - 16-byte AES state; byte i is row i%4, column i/4
//   word_t       - 32-bit key-schedule word, bits [31:24] = row 0
//   NR_AES128    - number of rounds for AES-128
//   fsm_state_t  - cipher control states
//   xtime, shift_rows, mix_columns - GF(2^8) round helpers
package aes_pkg;

    typedef logic [0:15][7:0] state_t;
    typedef logic [31:0] word_t;

    localparam int NR_AES128 = 10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_state_t;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotates left by r columns.
    function automatic state_t shift_rows(input state_t s);
        state_t r;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[4*c + row] = s[4*((c + row) % 4) + row];
            end
        end
        return r;
    endfunction

    // Each column is multiplied by the fixed polynomial {03}x^3+{01}x^2+{01}x+{02};
    // {03}*a is formed as xtime(a)^a.
    function automatic state_t mix_columns(input state_t s);
        state_t r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4*c];
            a1 = s[4*c + 1];
            a2 = s[4*c + 2];
            a3 = s[4*c + 3];
            r[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (SubBytes for a single byte).
// Ports:
//   addr  - input byte
//   value - substituted byte
module aes_sbox (
    input  logic [7:0] addr,
    output logic [7:0] value
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign value = SBOX[addr];

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption core: one round per clock, valid/ready on
// both sides, one block in flight at a time.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   key_schedule  - round-key words w[0..43], held stable while a block runs
//   in_data       - plaintext, [127:120] = state byte 0
//   in_valid      - plaintext present
//   in_ready      - core idle and able to accept a block
//   out_data      - ciphertext (zero when out_valid is low)
//   out_valid     - ciphertext valid, held until out_ready
//   out_ready     - consumer accepts ciphertext
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:43][31:0] key_schedule,
    input  logic [127:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [127:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    if (NR != NR_AES128) begin : g_nr_check
        $error("aes_cipher_core: only NR=10 (AES-128) is supported");
    end

    fsm_state_t fsm_state, fsm_next;
    logic [3:0] round_q, round_next;
    state_t     state_q, state_next;

    state_t     sub_bytes, shifted, mixed, round_key, key0;
    logic [5:0] rk_base;
    logic       last_round;

    // SubBytes: one S-box per state byte.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .addr  (state_q[i]),
            .value (sub_bytes[i])
        );
    end

    assign shifted    = shift_rows(sub_bytes);
    assign mixed      = mix_columns(shifted);
    assign last_round = (round_q == 4'(NR));
    assign key0       = key_schedule[0:3];

    // Out-of-range counter values select round key 0 so the word index never
    // runs past w[43]; the FSM discards the result in that case anyway.
    assign rk_base = (round_q <= 4'(NR)) ? {round_q, 2'b00} : 6'd0;

    always_comb begin
        round_key = '0;
        for (int c = 0; c < 4; c++) begin
            round_key[4*c +: 4] = key_schedule[rk_base + 6'(c)];
        end
    end

    // State register, round counter and FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_state <= IDLE;
            round_q   <= 4'd0;
            state_q   <= '0;
        end else begin
            fsm_state <= fsm_next;
            round_q   <= round_next;
            state_q   <= state_next;
        end
    end

    // Next-state and handshake logic. Outputs are held low during the reset
    // cycle so no handshake can complete while the core is being cleared.
    always_comb begin
        fsm_next   = fsm_state;
        round_next = round_q;
        state_next = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        case (fsm_state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_next = state_t'(in_data) ^ key0;
                    round_next = 4'd1;
                    fsm_next   = RUN;
                end
            end
            RUN: begin
                if (round_q == 4'd0 || round_q > 4'(NR)) begin
                    // Unreachable counter value: abandon and recover.
                    round_next = 4'd0;
                    fsm_next   = IDLE;
                end else if (last_round) begin
                    state_next = shifted ^ round_key;
                    fsm_next   = DONE;
                end else begin
                    state_next = mixed ^ round_key;
                    round_next = round_q + 4'd1;
                end
            end
            DONE: begin
                out_valid = !rst;
                out_data  = rst ? '0 : state_q;
                if (out_ready) begin
                    fsm_next = IDLE;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    // The schedule is not latched, so it must not move while rounds execute.
    key_stable_a: assert property (@(posedge clk) disable iff (rst)
        (fsm_state == RUN) |-> (key_schedule == $past(key_schedule)));

endmodule

// File: tb/tb_aes_cipher_core.sv
// Self-checking bench for aes_cipher_core: known-answer vectors, latency,
// backpressure, busy input, mid-run reset and back-to-back blocks.
module tb_aes_cipher_core;

    typedef logic [0:43][31:0] sched_t;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    sched_t        key_schedule = '0;
    logic [127:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;

    int n_compared = 0;
    int n_mismatch = 0;
    int cyc = 0;

    logic [7:0] tb_sbox [256];

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_cipher_core dut (
        .clk          (clk),
        .rst          (rst),
        .key_schedule (key_schedule),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box derived from the multiplicative inverse plus affine transform.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            tb_sbox[x] = s;
        end
    endtask

    function automatic sched_t ref_expand(input logic [127:0] key);
        sched_t w;
        logic [31:0] t;
        logic [7:0] rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return w;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
        sched_t w;
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        w = ref_expand(key);
        for (int i = 0; i < 16; i++)
            s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = tb_sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[rr + 4*c] = t[rr + 4*((c + rr) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- tasks ----------------
    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents a block and returns at the negedge of cycle 1 after acceptance.
    task automatic apply_stimulus(input logic [127:0] key, input logic [127:0] pt, output int accept_cyc);
        int guard = 0;
        @(negedge clk);
        key_schedule = ref_expand(key);
        in_data  = pt;
        in_valid = 1'b1;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check_output("accept_timeout", 128'(in_ready), 128'd1);
        accept_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts cycles from acceptance until out_valid is seen (bounded).
    task automatic wait_output(output logic [127:0] ct, output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ct = out_data;
    endtask

    task automatic run_vector(input string name, input logic [127:0] key,
                              input logic [127:0] pt, input logic [127:0] exp_ct);
        int acc, lat;
        logic [127:0] ct;
        apply_stimulus(key, pt, acc);
        wait_output(ct, lat);
        check_output({name, "_ct"}, ct, exp_ct);
        check_output({name, "_latency"}, 128'(lat), 128'd11);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t vecs [3];
        int acc, lat, prev_acc, seen;
        logic [127:0] ct, key_r, pt_r, pt2;

        build_sbox();

        vecs[0] = '{"app_b",  KEY_B, PT_B, CT_B};
        vecs[1] = '{"app_c1", KEY_C, PT_C, CT_C};
        vecs[2] = '{"zero",   128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_output("rst_in_ready", 128'(in_ready), 128'd0);
        check_output("rst_out_valid", 128'(out_valid), 128'd0);
        check_output("rst_out_data", out_data, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output("idle_in_ready", 128'(in_ready), 128'd1);
        check_output("idle_out_valid", 128'(out_valid), 128'd0);

        // Known-answer table
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            run_vector(vecs[v].name, vecs[v].key, vecs[v].pt, vecs[v].ct);
            @(negedge clk);
            check_output({vecs[v].name, "_drop_valid"}, 128'(out_valid), 128'd0);
            check_output({vecs[v].name, "_idle_ready"}, 128'(in_ready), 128'd1);
        end

        // Backpressure: hold ciphertext for 20 cycles
        out_ready = 1'b0;
        apply_stimulus(KEY_B, PT_B, acc);
        wait_output(ct, lat);
        check_output("bp_ct", ct, CT_B);
        check_output("bp_latency", 128'(lat), 128'd11);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_output("bp_hold_valid", 128'(out_valid), 128'd1);
            check_output("bp_hold_data", out_data, CT_B);
            check_output("bp_hold_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_output("bp_release_valid", 128'(out_valid), 128'd0);
        check_output("bp_release_ready", 128'(in_ready), 128'd1);

        // Input while busy: pulses at cycles 3 and 7 must be ignored
        pt2 = 128'h0123456789abcdeffedcba9876543210;
        apply_stimulus(KEY_C, PT_C, acc);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 3 || lat == 7) begin
                in_valid = 1'b1;
                in_data  = pt2;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check_output("busy_ct", out_data, CT_C);
        check_output("busy_latency", 128'(lat), 128'd11);
        @(negedge clk);
        check_output("busy_no_second_valid", 128'(out_valid), 128'd0);
        check_output("busy_idle_ready", 128'(in_ready), 128'd1);
        run_vector("busy_second", KEY_C, pt2, ref_encrypt(KEY_C, pt2));

        // Reset in the fifth RUN cycle
        apply_stimulus(KEY_B, PT_B, acc);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("midrst_out_valid", 128'(out_valid), 128'd0);
        check_output("midrst_out_data", out_data, 128'd0);
        rst = 1'b0;
        #1;
        check_output("midrst_in_ready", 128'(in_ready), 128'd1);
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_output("midrst_no_output", 128'(seen), 128'd0);
        run_vector("midrst_after", KEY_B, PT_B, CT_B);

        // Back-to-back random blocks, out_ready held high
        prev_acc = 0;
        for (int k = 0; k < 4; k++) begin
            key_r = {$urandom, $urandom, $urandom, $urandom};
            pt_r  = {$urandom, $urandom, $urandom, $urandom};
            apply_stimulus(key_r, pt_r, acc);
            wait_output(ct, lat);
            check_output("b2b_ct", ct, ref_encrypt(key_r, pt_r));
            check_output("b2b_latency", 128'(lat), 128'd11);
            if (k > 0) check_output("b2b_spacing", 128'(acc - prev_acc), 128'd12);
            prev_acc = acc;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
